// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_scan_pkg;

    // Display slot phase: all selects off, or current digit driven.
    typedef enum logic [0:0] {
        ST_BLANK,
        ST_SHOW
    } state_e;

    localparam int unsigned DIGIT_W              = 4;
    localparam int unsigned DEFAULT_PRESCALE     = 10000;
    localparam int unsigned DEFAULT_BLANK_CYCLES = 16;

endpackage

// File: rtl/seg_scan_timer.sv
// Slot timer for the scan controller: counts 0..PRESCALE-1 and wraps.
// in_blank covers the first BLANK_CYCLES counts of every slot.
module seg_scan_timer
    import seg_scan_pkg::*;
#(
    parameter int unsigned PRESCALE     = DEFAULT_PRESCALE,
    parameter int unsigned BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    output logic cnt_wrap,
    output logic in_blank
);

    localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Next count and slot-phase decode from the current count.
    always_comb begin
        cnt_wrap = (cnt_q == CntW'(PRESCALE - 1));
        in_blank = (cnt_q < CntW'(BLANK_CYCLES));
        cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
    end

    // Slot counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// Holds one code per digit, steps through the digits one slot at a time and
// blanks all selects at the start of each slot to avoid ghosting.
// Optional decimal-point storage and output: define SEG_SCAN_DP_EN.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned PRESCALE     = DEFAULT_PRESCALE,
    parameter int unsigned BLANK_CYCLES = DEFAULT_BLANK_CYCLES,
    parameter int unsigned ADDR_W       = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DIGIT_W-1:0]    wr_data,
`ifdef SEG_SCAN_DP_EN
    input  logic                  wr_dp,
`endif
    input  logic [NUM_DIGITS-1:0] digit_en,
    output logic [DIGIT_W-1:0]    dig_code,
    output logic [NUM_DIGITS-1:0] dig_sel,
    output logic                  seg_blank,
`ifdef SEG_SCAN_DP_EN
    output logic                  dp_out,
`endif
    output logic                  frame_tick
);

    logic   cnt_wrap;
    logic   in_blank;
    state_e state;

    seg_scan_timer #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .cnt_wrap (cnt_wrap),
        .in_blank (in_blank)
    );

    logic [DIGIT_W-1:0]    digit_q [NUM_DIGITS];
    logic [DIGIT_W-1:0]    digit_d [NUM_DIGITS];
    logic [ADDR_W-1:0]     idx_q;
    logic [ADDR_W-1:0]     idx_d;
    logic [DIGIT_W-1:0]    code_q;
    logic [DIGIT_W-1:0]    code_d;
    logic [NUM_DIGITS-1:0] sel_q;
    logic [NUM_DIGITS-1:0] sel_d;
    logic                  blank_q;
    logic                  blank_d;
    logic                  tick_q;
    logic                  tick_d;
    logic                  wr_hit;

    // Out-of-range addresses are dropped.
    assign wr_hit = wr_en && (32'(wr_addr) < NUM_DIGITS);

    // Register-file write and digit index advance on slot wrap.
    always_comb begin
        digit_d = digit_q;
        if (wr_hit) begin
            digit_d[wr_addr] = wr_data;
        end
        idx_d = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == ADDR_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Slot phase and registered-output next values; code is presented in
    // both phases so the shared decoder settles while selects are off.
    always_comb begin
        state   = in_blank ? ST_BLANK : ST_SHOW;
        sel_d   = '0;
        blank_d = 1'b1;
        code_d  = digit_q[idx_q];
        // idx reads 0 on the cycle after the last digit's slot wraps.
        tick_d  = cnt_wrap && (idx_q == ADDR_W'(NUM_DIGITS - 1));
        if (state == ST_SHOW && digit_en[idx_q]) begin
            sel_d[idx_q] = 1'b1;
            blank_d      = 1'b0;
        end
    end

    // Digit registers, index and all display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= '0;
            end
            idx_q   <= '0;
            code_q  <= '0;
            sel_q   <= '0;
            blank_q <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            digit_q <= digit_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            sel_q   <= sel_d;
            blank_q <= blank_d;
            tick_q  <= tick_d;
        end
    end

    assign dig_code   = code_q;
    assign dig_sel    = sel_q;
    assign seg_blank  = blank_q;
    assign frame_tick = tick_q;

`ifdef SEG_SCAN_DP_EN
    logic [NUM_DIGITS-1:0] dp_q;
    logic [NUM_DIGITS-1:0] dp_d;
    logic                  dp_out_q;
    logic                  dp_out_d;

    // Decimal-point storage follows the digit write; output gated like dig_sel.
    always_comb begin
        dp_d = dp_q;
        if (wr_hit) begin
            dp_d[wr_addr] = wr_dp;
        end
        dp_out_d = dp_q[idx_q] && (state == ST_SHOW) && digit_en[idx_q];
    end

    // Decimal-point registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_q     <= '0;
            dp_out_q <= 1'b0;
        end else begin
            dp_q     <= dp_d;
            dp_out_q <= dp_out_d;
        end
    end

    assign dp_out = dp_out_q;
`endif

endmodule
